svm_decision_acc: RTL and testbench
===================================

# svm_decision_acc

Downstream decision stage of the SVM Gaussian classifier. It consumes the per-support-vector kernel stream (one kernel value K_i per beat, framed by sop/valid/eop), multiplies each K_i by a stored signed coefficient alpha_i·y_i, accumulates the products, adds the bias, and emits a Q16.16 decision score and a binary class once per packet. Coefficients and bias are loaded through a simple write port before classification starts.

## Interface
- DATA_W, 32, width of kernel values, coefficients, bias and score (signed Q(DATA_W-FRAC).FRAC)
- FRAC, 16, fractional bits
- N_SV, 4, support vectors per packet; also coefficient memory depth
- ADDR_W, 2, coefficient address width; must equal clog2(N_SV), minimum 1

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_k  in  DATA_W  kernel value K_i, signed Q16.16
- sop_k  in  1  first beat of packet, qualified by valid_k
- valid_k  in  1  beat valid
- eop_k  in  1  last beat of packet, qualified by valid_k
- coef_we  in  1  coefficient write strobe
- coef_addr  in  ADDR_W  coefficient index
- coef_data  in  DATA_W  signed alpha_i·y_i, Q16.16
- bias_we  in  1  bias write strobe
- bias_data  in  DATA_W  signed bias, Q16.16
- output_score  out  DATA_W  saturated decision score
- output_c  out  1  class: 1 if score >= 0, else 0
- valid_c  out  1  one-cycle pulse, score/class valid
- err_c  out  1  framing error for the packet reported with this valid_c

## Operation
- Framing FSM: IDLE, ACCUM.
  - IDLE: valid_k&sop_k -> beat accepted, index 0, go ACCUM (or stay IDLE if eop_k same cycle). valid_k without sop_k ignored.
  - ACCUM: valid_k accepted, index increments; valid_k&eop_k -> IDLE. valid_k&sop_k mid-packet -> current packet aborted (no valid_c), new packet starts at index 0, err flag set for the new packet.
- Beat with index >= N_SV: product forced to 0, err flag set. Packet ending with beat count != N_SV: result still produced, err_c=1.
- Coefficient read: coef[index] sampled on accept. Write and read same address same cycle -> old value read. Writes take effect next cycle. bias sampled in the accumulate stage of the last beat.
- Arithmetic: product = K·coef, full 2·DATA_W signed. Accumulator 2·DATA_W+ADDR_W+1 bits signed, no overflow possible. First beat loads accumulator, later beats add. Score = (acc >>> FRAC, arithmetic, truncate toward −inf) + sign-extended bias, then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Coefficients and bias reset to 0.

## Timing
- Reset values: output_score=0, output_c=0, valid_c=0, err_c=0, FSM IDLE, pipeline flags cleared; accepted-but-unfinished packet discarded.
- Pipeline: S1 registers product + first/last/err tags; S2 accumulates; S3 adds bias, saturates, registers outputs.
- Latency: eop beat sampled at edge T -> valid_c high for exactly the cycle after edge T+3.
- Fully pipelined: one beat per cycle; sop may follow eop on the next cycle with no bubble; back-to-back results produce valid_c on consecutive packet boundaries.
- output_score/output_c/err_c hold their last value between valid_c pulses.
- rst asserted mid-packet: all in-flight beats dropped, no valid_c for them.

## Test plan
- All coef 0x00010000, bias 0xFFFF0000 (−1.0), packet of 4 beats K=0x00008000 -> score 0x00010000, output_c=1, err_c=0, valid_c 3 cycles after eop edge.
- Same, bias 0xFFFD0000 (−3.0) -> score 0xFFFF0000, output_c=0.
- All coef and K = 0x7FFF0000, bias 0 -> score saturates 0x7FFFFFFF, output_c=1; all coef = 0x80000000, K=0x7FFF0000 -> score 0x80000000, output_c=0.
- 3-beat packet, then 5-beat packet -> both valid_c with err_c=1; 5th beat contributes 0.
- sop at beat 2 of a packet, then full 4-beat packet -> exactly one valid_c, err_c=1; rst at beat 3 -> no valid_c, outputs 0.
- Two packets back-to-back (sop cycle after eop), coef rewritten between -> two valid_c pulses 4 cycles apart, each using coefficients current at its beats.

Source files
------------

// File: rtl/svm_decision_acc_if.sv
// Bundles the kernel stream, coefficient/bias write port and decision outputs of svm_decision_acc.
// Ports: input_k/sop_k/valid_k/eop_k (kernel beats), coef_we/coef_addr/coef_data, bias_we/bias_data,
//        output_score/output_c/valid_c/err_c (one result per packet). master = source side, slave = the block.
interface svm_decision_acc_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] input_k;
    logic              sop_k;
    logic              valid_k;
    logic              eop_k;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              bias_we;
    logic [DATA_W-1:0] bias_data;
    logic [DATA_W-1:0] output_score;
    logic              output_c;
    logic              valid_c;
    logic              err_c;

    modport master (
        output input_k, sop_k, valid_k, eop_k,
        output coef_we, coef_addr, coef_data, bias_we, bias_data,
        input  output_score, output_c, valid_c, err_c
    );

    modport slave (
        input  input_k, sop_k, valid_k, eop_k,
        input  coef_we, coef_addr, coef_data, bias_we, bias_data,
        output output_score, output_c, valid_c, err_c
    );
endinterface

// File: rtl/svm_decision_acc.sv
// SVM decision stage: score = sat(sum(K_i * coef_i) >>> FRAC + bias), class = score >= 0, one result per packet.
// Latency: eop beat accepted at edge T -> valid_c high for the cycle after edge T+3 (accept, multiply, accumulate, output).
// Backpressure: none; accepts one beat every cycle, back-to-back packets need no bubble.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries kernel stream, coef/bias writes and score/class/err outputs.
module svm_decision_acc #(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int N_SV   = 4,
    parameter int ADDR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    svm_decision_acc_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + ADDR_W + 1;
    localparam int SUM_W  = ACC_W + 1;
    localparam int IDX_W  = ADDR_W + 1;
    // Beat index saturates at N_SV: every beat past the last support vector is treated alike.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SV - 1);
    localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(N_SV);

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    state_t             r_state, w_state_nxt;
    logic               w_accept, w_first, w_abort;
    logic [IDX_W-1:0]   r_idx, w_idx_cur, w_idx_nxt;
    logic               w_oob, w_bad_end, w_beat_err;

    logic [DATA_W-1:0]  r_coef [N_SV];
    logic [DATA_W-1:0]  r_bias;

    logic               r_s0_vld, r_s0_first, r_s0_last, r_s0_err;
    logic [DATA_W-1:0]  r_s0_k, r_s0_coef;

    logic               r_s1_vld, r_s1_first, r_s1_last, r_s1_err;
    logic [PROD_W-1:0]  w_prod, r_s1_prod;

    logic               r_s2_done, r_s2_err;
    logic signed [ACC_W-1:0] r_s2_acc;
    logic [DATA_W-1:0]  r_s2_bias;

    logic signed [ACC_W-1:0] w_shift;
    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-DATA_W:0] w_hi;
    logic               w_ovf;
    logic [DATA_W-1:0]  w_score;

    logic [DATA_W-1:0]  r_score;
    logic               r_class, r_valid, r_err;

    // ---------------- framing FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_first     = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.valid_k && bus.sop_k) begin
                    w_accept    = 1'b1;
                    w_first     = 1'b1;
                    w_state_nxt = bus.eop_k ? ST_IDLE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.valid_k) begin
                    w_accept = 1'b1;
                    // A sop mid-packet restarts accumulation; the old packet never reaches the output.
                    w_first  = bus.sop_k;
                    w_abort  = bus.sop_k;
                    if (bus.eop_k) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_idx_cur  = w_first ? '0 : r_idx;
    assign w_idx_nxt  = (w_idx_cur >= IDX_SAT) ? IDX_SAT : w_idx_cur + IDX_W'(1);
    assign w_oob      = (w_idx_cur >= IDX_SAT);
    assign w_bad_end  = bus.eop_k && (w_idx_cur != IDX_LAST);
    assign w_beat_err = w_oob || w_bad_end || w_abort;

    always_ff @(posedge clk) begin
        if (rst)           r_idx <= '0;
        else if (w_accept) r_idx <= w_idx_nxt;
    end

    // ---------------- coefficient / bias storage ----------------
    // Registered read at accept: a same-cycle write to the same address is seen by the next beat only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SV; i++) r_coef[i] <= '0;
            r_bias <= '0;
        end else begin
            if (bus.coef_we) r_coef[bus.coef_addr] <= bus.coef_data;
            if (bus.bias_we) r_bias <= bus.bias_data;
        end
    end

    // ---------------- S0: accepted beat + coefficient ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_vld   <= 1'b0;
            r_s0_first <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_k     <= '0;
            r_s0_coef  <= '0;
        end else begin
            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_s0_first <= w_first;
                r_s0_last  <= bus.eop_k;
                r_s0_err   <= w_beat_err;
                r_s0_k     <= bus.input_k;
                // Zero coefficient for out-of-range beats forces their product to 0.
                r_s0_coef  <= w_oob ? '0 : r_coef[w_idx_cur[ADDR_W-1:0]];
            end
        end
    end

    // ---------------- S1: full-width signed product ----------------
    // Operands sign-extended to PROD_W so the low PROD_W bits are the exact signed product.
    assign w_prod = {{DATA_W{r_s0_k[DATA_W-1]}}, r_s0_k} * {{DATA_W{r_s0_coef[DATA_W-1]}}, r_s0_coef};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_prod  <= '0;
        end else begin
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_first <= r_s0_first;
                r_s1_last  <= r_s0_last;
                r_s1_err   <= r_s0_err;
                r_s1_prod  <= w_prod;
            end
        end
    end

    // ---------------- S2: accumulate, capture bias on the last beat ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_done <= 1'b0;
            r_s2_err  <= 1'b0;
            r_s2_acc  <= '0;
            r_s2_bias <= '0;
        end else begin
            r_s2_done <= r_s1_vld && r_s1_last;
            if (r_s1_vld) begin
                if (r_s1_first) begin
                    r_s2_acc <= {{(ACC_W-PROD_W){r_s1_prod[PROD_W-1]}}, r_s1_prod};
                    r_s2_err <= r_s1_err;
                end else begin
                    r_s2_acc <= r_s2_acc + {{(ACC_W-PROD_W){r_s1_prod[PROD_W-1]}}, r_s1_prod};
                    r_s2_err <= r_s2_err || r_s1_err;
                end
                if (r_s1_last) r_s2_bias <= r_bias;
            end
        end
    end

    // ---------------- S3: scale, add bias, saturate ----------------
    assign w_shift = r_s2_acc >>> FRAC;
    assign w_sum   = {w_shift[ACC_W-1], w_shift} + {{(SUM_W-DATA_W){r_s2_bias[DATA_W-1]}}, r_s2_bias};
    // Result fits DATA_W only if every bit from the DATA_W sign position upward agrees.
    assign w_hi    = w_sum[SUM_W-1:DATA_W-1];
    assign w_ovf   = !((&w_hi) || !(|w_hi));
    assign w_score = !w_ovf ? w_sum[DATA_W-1:0] :
                     w_sum[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_score <= '0;
            r_class <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= r_s2_done;
            if (r_s2_done) begin
                r_score <= w_score;
                r_class <= !w_score[DATA_W-1];
                r_err   <= r_s2_err;
            end
        end
    end

    assign bus.output_score = r_score;
    assign bus.output_c     = r_class;
    assign bus.valid_c      = r_valid;
    assign bus.err_c        = r_err;
endmodule

// File: tb/tb_svm_decision_acc.sv
// Self-checking bench for svm_decision_acc: directed test-plan packets plus randomized packets,
// every result compared against an arithmetic reference model (wide-integer sum, floor shift, clamp).
module tb_svm_decision_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    svm_decision_acc_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    svm_decision_acc #(.DATA_W(32), .FRAC(16), .N_SV(4), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] score;
        logic        c;
        logic        err;
        int          cyc;
    } res_t;

    res_t        got_q[$];
    res_t        exp_q[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] sh_coef [4];
    logic [31:0] sh_bias;
    logic [31:0] pk [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.valid_c === 1'b1)
            got_q.push_back('{bus.output_score, bus.output_c, bus.err_c, cyc});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of K_i*coef_i over the first 4 beats, floor-divide by 2^16, add bias, clamp.
    function automatic res_t model(input logic [31:0] ks [8], input logic [31:0] cf [4],
                                   input logic [31:0] bias, input int n, input bit force_err);
        logic signed [127:0] acc, a, b, t;
        logic signed [127:0] maxv, minv;
        res_t r;
        maxv = 128'sh7FFFFFFF;
        minv = -128'sh80000000;
        acc  = '0;
        for (int i = 0; i < n && i < 4; i++) begin
            a   = $signed(ks[i]);
            b   = $signed(cf[i]);
            acc = acc + a * b;
        end
        t = (acc >>> 16) + $signed(bias);
        if (t > maxv) t = maxv;
        else if (t < minv) t = minv;
        r.score = t[31:0];
        r.c     = !t[127];
        r.err   = force_err || (n != 4);
        r.cyc   = 0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [31:0] d);
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        tick();
        bus.coef_we = 1'b0;
        sh_coef[a] = d;
    endtask

    task automatic write_bias(input logic [31:0] d);
        bus.bias_we = 1'b1; bus.bias_data = d;
        tick();
        bus.bias_we = 1'b0;
        sh_bias = d;
    endtask

    task automatic beat(input logic [31:0] k, input bit s, input bit e, input bit we,
                        input logic [1:0] wa, input logic [31:0] wd, output int ecyc);
        bus.input_k = k; bus.sop_k = s; bus.eop_k = e; bus.valid_k = 1'b1;
        bus.coef_we = we; bus.coef_addr = wa; bus.coef_data = wd;
        tick();
        ecyc = cyc;
        bus.valid_k = 1'b0; bus.sop_k = 1'b0; bus.eop_k = 1'b0; bus.coef_we = 1'b0;
        if (we) sh_coef[wa] = wd;
    endtask

    // Sends pk[0..n-1] as one packet; optional coefficient write rides on the eop beat.
    task automatic send_pkt(input int n, input bit force_err, input bit we,
                            input logic [1:0] wa, input logic [31:0] wd);
        res_t e;
        int   ec;
        e = model(pk, sh_coef, sh_bias, n, force_err);
        ec = 0;
        for (int i = 0; i < n; i++)
            beat(pk[i], i == 0, i == n - 1, we && (i == n - 1), wa, wd, ec);
        e.cyc = ec + 3;
        exp_q.push_back(e);
    endtask

    task automatic check_result(input string tag, output res_t g);
        res_t e;
        int   w;
        w = 0;
        while (got_q.size() == 0 && w < 40) begin
            @(negedge clk); #1;
            w++;
        end
        g = '{score: '0, c: 1'b0, err: 1'b0, cyc: 0};
        if (got_q.size() == 0) begin
            chk({tag, "_timeout"}, 64'(got_q.size()), 64'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_score"},   64'(g.score), 64'(e.score));
            chk({tag, "_class"},   64'(g.c),     64'(e.c));
            chk({tag, "_err"},     64'(g.err),   64'(e.err));
            chk({tag, "_latency"}, 64'(g.cyc),   64'(e.cyc));
        end
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) tick();
        chk({tag, "_no_result"}, 64'(got_q.size()), 64'd0);
        got_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t g, g2;
        int   ec;
        bus.input_k = '0; bus.sop_k = 1'b0; bus.valid_k = 1'b0; bus.eop_k = 1'b0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus.bias_we = 1'b0; bus.bias_data = '0;
        for (int i = 0; i < 4; i++) sh_coef[i] = '0;
        sh_bias = '0;
        ec = 0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_score", 64'(bus.output_score), 64'd0);
        chk("reset_class", 64'(bus.output_c),     64'd0);
        chk("reset_valid", 64'(bus.valid_c),      64'd0);
        chk("reset_err",   64'(bus.err_c),        64'd0);

        // Unit coefficients, bias -1.0, K = 0.5 x4 -> +1.0
        for (int i = 0; i < 4; i++) write_coef(2'(i), 32'h0001_0000);
        write_bias(32'hFFFF_0000);
        for (int i = 0; i < 8; i++) pk[i] = 32'h0000_8000;
        send_pkt(4, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("tp1", g);
        chk("tp1_const", 64'(g.score), 64'h0001_0000);

        write_bias(32'hFFFD_0000);
        send_pkt(4, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("tp2", g);
        chk("tp2_const", 64'(g.score), 64'hFFFF_0000);

        // Saturation both ways
        for (int i = 0; i < 4; i++) write_coef(2'(i), 32'h7FFF_0000);
        write_bias(32'h0);
        for (int i = 0; i < 8; i++) pk[i] = 32'h7FFF_0000;
        send_pkt(4, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("sat_pos", g);
        chk("sat_pos_const", 64'(g.score), 64'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) write_coef(2'(i), 32'h8000_0000);
        send_pkt(4, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("sat_neg", g);
        chk("sat_neg_const", 64'(g.score), 64'h8000_0000);

        // Short and long packets
        for (int i = 0; i < 4; i++) write_coef(2'(i), 32'h0001_0000 * (i + 1));
        write_bias(32'h0000_4000);
        for (int i = 0; i < 8; i++) pk[i] = 32'h0000_1000 * (i + 1);
        send_pkt(3, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("short3", g);
        send_pkt(5, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("long5", g);

        // sop mid-packet aborts the first packet; only the restarted one reports
        beat(32'h0005_0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, ec);
        beat(32'h0006_0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, ec);
        send_pkt(4, 1'b1, 1'b0, 2'd0, 32'd0);
        check_result("abort", g);
        check_quiet("abort", 8);

        // Reset mid-packet drops everything in flight
        beat(32'h0001_0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, ec);
        beat(32'h0001_0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, ec);
        beat(32'h0001_0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, ec);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) sh_coef[i] = '0;
        sh_bias = '0;
        check_quiet("rst_mid", 10);
        chk("rst_mid_score", 64'(bus.output_score), 64'd0);
        chk("rst_mid_class", 64'(bus.output_c),     64'd0);
        chk("rst_mid_err",   64'(bus.err_c),        64'd0);

        // Back-to-back packets; coef[3] rewritten on the first packet's eop beat
        for (int i = 0; i < 4; i++) write_coef(2'(i), 32'h0002_0000);
        write_bias(32'hFFFF_8000);
        for (int i = 0; i < 8; i++) pk[i] = 32'h0000_C000;
        send_pkt(4, 1'b0, 1'b1, 2'd3, 32'hFFF0_0000);
        send_pkt(4, 1'b0, 1'b0, 2'd0, 32'd0);
        check_result("b2b_first", g);
        check_result("b2b_second", g2);
        chk("b2b_spacing", 64'(g2.cyc - g.cyc), 64'd4);

        // Randomized packets, lengths 1..6
        for (int p = 0; p < 16; p++) begin
            for (int i = 0; i < 4; i++)
                write_coef(2'(i), $unsigned($signed($urandom) >>> $urandom_range(4, 14)));
            write_bias($unsigned($signed($urandom) >>> $urandom_range(0, 12)));
            for (int i = 0; i < 8; i++)
                pk[i] = $unsigned($signed($urandom) >>> $urandom_range(4, 14));
            send_pkt(int'($urandom_range(1, 6)), 1'b0, 1'b0, 2'd0, 32'd0);
            check_result($sformatf("rand%0d", p), g);
        end

        check_quiet("final", 8);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
